// File: rtl/instr_controller_if.sv
// Handshake/control bundle between the instruction controller and its
// neighbours (instruction source on one side, datapath on the other).
//   s, load, in        : start request, IR load enable, instruction word
//   w, illegal         : idle/ready flag, undefined-encoding pulse
//   readnum..loads     : datapath control inputs
//   sximm5, sximm8     : sign-extended immediates from the IR
// master = instruction source / bench, slave = instr_controller.
interface instr_controller_if;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        output s, load, in,
        input  w, illegal, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, shift, ALUop, loadc, loads, sximm5, sximm8
    );

    modport slave (
        input  s, load, in,
        output w, illegal, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, shift, ALUop, loadc, loads, sximm5, sximm8
    );
endinterface

// File: rtl/instr_controller.sv
// Instruction register, decoder and Moore control FSM feeding the datapath.
// Sequences one instruction (MOV imm, MOV reg, ADD, CMP, AND, MVN) per start
// request, one state per register-file / register access.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (IR=0, FSM to WAIT)
//   bus   : instr_controller_if.slave -- s/load/in in, all controls out
module instr_controller (
    input  logic               clk,
    input  logic               rst_n,
    instr_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WREG
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    // instruction fields
    logic [2:0] op, rn, rd, rm;
    logic [1:0] sub, sh;
    assign op  = ir_q[15:13];
    assign sub = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    logic is_movi, is_movr, is_alu, is_cmp, is_mvn;
    assign is_movi = (op == 3'b110) && (sub == 2'b10);
    assign is_movr = (op == 3'b110) && (sub == 2'b00);
    assign is_alu  = (op == 3'b101);
    assign is_cmp  = is_alu && (sub == 2'b01);
    assign is_mvn  = is_alu && (sub == 2'b11);

    // IR only accepts a new word while idle; DECODE therefore always sees
    // the word present when s was sampled.
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && bus.load)
            ir_d = bus.in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    logic       w_c, illegal_c, write_c, loada_c, loadb_c, asel_c, bsel_c;
    logic       loadc_c, loads_c;
    logic [2:0] readnum_c, writenum_c;
    logic [3:0] vsel_c;
    logic [1:0] shift_c, aluop_c;

    always_comb begin
        state_d    = state_q;
        w_c        = 1'b0;
        illegal_c  = 1'b0;
        readnum_c  = 3'd0;
        writenum_c = 3'd0;
        write_c    = 1'b0;
        vsel_c     = 4'b0001;   // C path is the resting write-data select
        loada_c    = 1'b0;
        loadb_c    = 1'b0;
        asel_c     = 1'b0;
        bsel_c     = 1'b0;
        shift_c    = 2'b00;
        aluop_c    = 2'b00;
        loadc_c    = 1'b0;
        loads_c    = 1'b0;

        case (state_q)
            S_WAIT: begin
                w_c = 1'b1;
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_movi)                 state_d = S_WIMM;
                else if (is_movr || is_mvn)  state_d = S_GETB;   // single-operand
                else if (is_alu)             state_d = S_GETA;
                else begin
                    illegal_c = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WIMM: begin
                write_c    = 1'b1;
                writenum_c = rn;
                vsel_c     = 4'b0100;
                state_d    = S_WAIT;
            end
            S_GETA: begin
                readnum_c = rn;
                loada_c   = 1'b1;
                state_d   = S_GETB;
            end
            S_GETB: begin
                readnum_c = rm;
                loadb_c   = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                shift_c = sh;
                aluop_c = sub;
                if (is_movr) begin
                    // MOV reg is 0 + shifted B
                    asel_c  = 1'b1;
                    aluop_c = 2'b00;
                end
                if (is_cmp) begin
                    loads_c = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc_c = 1'b1;
                    state_d = S_WREG;
                end
            end
            S_WREG: begin
                write_c    = 1'b1;
                writenum_c = rd;
                vsel_c     = 4'b0001;
                state_d    = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign bus.w        = w_c;
    assign bus.illegal  = illegal_c;
    assign bus.readnum  = readnum_c;
    assign bus.writenum = writenum_c;
    assign bus.write    = write_c;
    assign bus.vsel     = vsel_c;
    assign bus.loada    = loada_c;
    assign bus.loadb    = loadb_c;
    assign bus.asel     = asel_c;
    assign bus.bsel     = bsel_c;
    assign bus.shift    = shift_c;
    assign bus.ALUop    = aluop_c;
    assign bus.loadc    = loadc_c;
    assign bus.loads    = loads_c;
    assign bus.sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
    assign bus.sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_instr_controller.sv
module tb_instr_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_controller_if bus ();

    instr_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // packed snapshot of every control output
    function automatic logic [22:0] ctl(input logic w_, input logic il, input logic [2:0] rn,
                                        input logic [2:0] wn, input logic wr, input logic [3:0] vs,
                                        input logic la, input logic lb, input logic as_,
                                        input logic bs, input logic [1:0] sh, input logic [1:0] op,
                                        input logic lc, input logic ls);
        return {w_, il, rn, wn, wr, vs, la, lb, as_, bs, sh, op, lc, ls};
    endfunction

    function automatic logic [22:0] obs_ctl();
        return {bus.w, bus.illegal, bus.readnum, bus.writenum, bus.write, bus.vsel,
                bus.loada, bus.loadb, bus.asel, bus.bsel, bus.shift, bus.ALUop,
                bus.loadc, bus.loads};
    endfunction

    function automatic logic [15:0] sx8(input logic [15:0] word);
        logic signed [7:0] v;
        v = word[7:0];
        return 16'(int'(v));
    endfunction

    function automatic logic [15:0] sx5(input logic [15:0] word);
        logic signed [4:0] v;
        v = word[4:0];
        return 16'(int'(v));
    endfunction

    localparam logic [22:0] IDLE = {1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 4'b0001, 8'd0, 1'b0, 1'b0};

    // Reference model: list of expected control snapshots for each busy cycle
    // of an instruction, plus the documented latency for its class.
    logic [22:0] exp_q[$];
    int          exp_lat;

    task automatic build(input logic [15:0] word);
        logic [2:0] op, rn, rd, rm;
        logic [1:0] sb, sh;
        logic movi, movr, alu, cmp, mvn, ill;
        op = word[15:13]; sb = word[12:11]; rn = word[10:8];
        rd = word[7:5];   sh = word[4:3];   rm = word[2:0];
        movi = (op == 3'd6 && sb == 2'd2);
        movr = (op == 3'd6 && sb == 2'd0);
        alu  = (op == 3'd5);
        cmp  = alu && sb == 2'd1;
        mvn  = alu && sb == 2'd3;
        ill  = !(movi || movr || alu);
        exp_q.delete();
        exp_q.push_back(ctl(0, ill, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0));
        if (ill) begin
            exp_lat = 1;
        end else if (movi) begin
            exp_q.push_back(ctl(0, 0, 0, rn, 1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0));
            exp_lat = 2;
        end else begin
            if (!(movr || mvn))
                exp_q.push_back(ctl(0, 0, rn, 0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(ctl(0, 0, rm, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(ctl(0, 0, 0, 0, 0, 4'b0001, 0, 0, movr, 0, sh,
                                movr ? 2'b00 : sb, !cmp, cmp));
            if (!cmp)
                exp_q.push_back(ctl(0, 0, 0, rd, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0));
            exp_lat = (movr || mvn || cmp) ? 4 : 5;
        end
    endtask

    // Issue one instruction from WAIT (called #1 after an edge) and follow it
    // back to WAIT. hold_s keeps s high afterwards; busy drives load=1 with an
    // illegal word throughout execution.
    task automatic run(input logic [15:0] word, input logic hold_s, input logic busy);
        int cyc;
        bit done;
        build(word);
        bus.in = word; bus.load = 1'b1; bus.s = 1'b1;
        cyc = 0; done = 0;
        while (!done && cyc < 12) begin
            @(posedge clk); #1;
            if (bus.w) done = 1;
            else begin
                if (cyc < exp_q.size()) chk("ctl", 32'(obs_ctl()), 32'(exp_q[cyc]));
                else chk("extra_busy_cycle", 32'(obs_ctl()), 32'(IDLE));
                chk("sximm8", 32'(bus.sximm8), 32'(sx8(word)));
                cyc++;
                bus.s = hold_s;
                bus.load = busy;
                if (busy) bus.in = 16'hE000;
            end
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("idle", 32'(obs_ctl()), 32'(IDLE));
        chk("ir_kept5", 32'(bus.sximm5), 32'(sx5(word)));
        bus.load = 1'b0;
        bus.in = word;
    endtask

    initial begin
        logic [4:0] tops[7];
        bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;

        // reset state
        #1;
        chk("reset_ctl", 32'(obs_ctl()), 32'(IDLE));
        chk("reset_sx8", 32'(bus.sximm8), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset", 32'(obs_ctl()), 32'(IDLE));

        // MOV R0,#-3
        run(16'hD0FD, 0, 0);
        // ADD R2,R1,R0,LSL#1
        run(16'hA148, 0, 0);
        // CMP R1,R0
        run(16'hA900, 0, 0);
        // busy load ignored during ADD, then illegal word
        run(16'hA148, 0, 1);
        run(16'hE000, 0, 0);
        // back-to-back: s held across MOV imm then MVN
        run(16'hD0FD, 1, 0);
        run(16'hB860, 0, 0);
        bus.s = 1'b0;

        // async reset mid-EXEC of an ADD
        @(posedge clk); #1;
        bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("exec_loadc", 32'(bus.loadc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_w", 32'(bus.w), 32'd1);
        chk("rst_loadc", 32'(bus.loadc), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_ctl", 32'(obs_ctl()), 32'(IDLE));
        chk("rst_ir", 32'(bus.sximm8), 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_wait", 32'(obs_ctl()), 32'(IDLE));

        // randomized instructions
        tops = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b00000};
        for (int i = 0; i < 60; i++) begin
            logic [15:0] word;
            int k;
            word = 16'($urandom);
            k = $urandom_range(0, 6);
            if (k < 6) word[15:11] = tops[k];
            run(word, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            bus.s = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                chk("rand_idle", 32'(obs_ctl()), 32'(IDLE));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
